// File: rtl/adsr_pkg.sv
// Shared types and constants for the ADSR beat scheduler.
package adsr_pkg;

    typedef logic [1:0] sched_state_t;

    localparam sched_state_t S_IDLE       = 2'd0;
    localparam sched_state_t S_WAIT_FRAME = 2'd1;
    localparam sched_state_t S_RUN        = 2'd2;

    localparam int TICK_HZ_DEFAULT = 250;
    localparam int TICKS_PER_MIN   = 60 * TICK_HZ_DEFAULT;

    function automatic int ticks_per_min(input int tick_hz);
        return 60 * tick_hz;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per clock, exactly W clocks per divide.
module seq_divider #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]     rem;
    logic [W-1:0]     dvsr;
    logic [CNT_W-1:0] step;
    logic [W:0]       rem_sh;
    logic [W:0]       diff;

    // quotient doubles as the dividend shift register; its MSB feeds the remainder
    assign rem_sh = {rem, quotient[W-1]};
    assign diff   = rem_sh - {1'b0, dvsr};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            rem      <= '0;
            dvsr     <= '0;
            quotient <= '0;
            step     <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                busy     <= 1'b1;
                step     <= '0;
                rem      <= '0;
                quotient <= dividend;
                dvsr     <= divisor;
            end else if (busy) begin
                if (!diff[W]) begin
                    rem      <= diff[W-1:0];
                    quotient <= {quotient[W-2:0], 1'b1};
                end else begin
                    rem      <= rem_sh[W-1:0];
                    quotient <= {quotient[W-2:0], 1'b0};
                end
                step <= step + 1'b1;
                if (step == CNT_W'(W - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/adsr_beat_scheduler.sv
// Converts BPM into a beat period in 4 ms ticks and issues frame-aligned envelope triggers.
module adsr_beat_scheduler
    import adsr_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 250,
    parameter int MIN_BPM  = 40,
    parameter int MAX_BPM  = 200,
    parameter int BPM_W    = $clog2(MAX_BPM + 1),
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BPM_W-1:0]    bpm_estimate,
    input  logic                bpm_valid,
    input  logic                sched_enable,
    input  logic                frame_start,
    output logic                tick_4ms,
    output logic                beat_trigger,
    output logic                gate,
    output logic [PERIOD_W-1:0] beat_period_ticks,
    output logic                filter_enable_cfg,
    output logic                div_busy
);

    localparam int TPM      = ticks_per_min(TICK_HZ);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int TCNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PERIOD_W-1:0] RESET_PERIOD = PERIOD_W'(TPM / MIN_BPM);
    localparam logic [PERIOD_W-1:0] DIVIDEND     = PERIOD_W'(TPM);

    if (longint'(TPM) >= (longint'(1) << PERIOD_W)) begin : g_width_check
        $error("60*TICK_HZ does not fit in PERIOD_W bits");
    end

    // tick generator: free-running, independent of sched_enable
    logic [TCNT_W-1:0] tick_cnt;

    assign tick_4ms = (tick_cnt == TCNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         tick_cnt <= '0;
        else if (tick_4ms) tick_cnt <= '0;
        else               tick_cnt <= tick_cnt + 1'b1;
    end

    // BPM intake; a value arriving mid-divide keeps div_req set for a re-divide
    logic [BPM_W-1:0]    shadow_bpm;
    logic [BPM_W-1:0]    bpm_clamped;
    logic                bpm_take;
    logic                div_req;
    logic                div_start;
    logic                div_done;
    logic [PERIOD_W-1:0] div_quot;

    always_comb begin
        bpm_clamped = bpm_estimate;
        if (bpm_estimate < BPM_W'(MIN_BPM))      bpm_clamped = BPM_W'(MIN_BPM);
        else if (bpm_estimate > BPM_W'(MAX_BPM)) bpm_clamped = BPM_W'(MAX_BPM);
    end

    assign bpm_take  = bpm_valid && (bpm_estimate != '0);
    assign div_start = div_req && !div_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_bpm <= '0;
            div_req    <= 1'b0;
        end else if (bpm_take) begin
            shadow_bpm <= bpm_clamped;
            div_req    <= 1'b1;
        end else if (div_start) begin
            div_req <= 1'b0;
        end
    end

    seq_divider #(.W(PERIOD_W)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (DIVIDEND),
        .divisor  ({{(PERIOD_W - BPM_W){1'b0}}, shadow_bpm}),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    // beat sequencer
    sched_state_t        state;
    logic [PERIOD_W-1:0] beat_cnt;
    logic [PERIOD_W-1:0] cnt_inc;
    logic [PERIOD_W-1:0] pending_period;
    logic                pend_valid;
    logic                have_result;
    logic                fire;

    assign fire              = sched_enable && (state == S_WAIT_FRAME) && frame_start;
    assign cnt_inc           = beat_cnt + 1'b1;
    assign filter_enable_cfg = (state == S_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= S_IDLE;
            beat_cnt          <= '0;
            gate              <= 1'b0;
            beat_trigger      <= 1'b0;
            beat_period_ticks <= RESET_PERIOD;
            pending_period    <= '0;
            pend_valid        <= 1'b0;
            have_result       <= 1'b0;
        end else begin
            beat_trigger <= 1'b0;
            if (div_done) begin
                pending_period <= div_quot;
                have_result    <= 1'b1;
            end
            // a fresh result on a trigger edge stays pending for the next beat
            if (div_done)  pend_valid <= 1'b1;
            else if (fire) pend_valid <= 1'b0;

            if (!sched_enable) begin
                state    <= S_IDLE;
                beat_cnt <= '0;
                gate     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (have_result) state <= S_WAIT_FRAME;
                    S_WAIT_FRAME: if (frame_start) begin
                        state        <= S_RUN;
                        beat_trigger <= 1'b1;
                        gate         <= 1'b1;
                        beat_cnt     <= '0;
                        if (pend_valid) beat_period_ticks <= pending_period;
                    end
                    S_RUN: if (tick_4ms) begin
                        beat_cnt <= cnt_inc;
                        if (cnt_inc >= (beat_period_ticks >> 1)) gate <= 1'b0;
                        if (cnt_inc == beat_period_ticks - 1'b1) begin
                            state <= S_WAIT_FRAME;
                            gate  <= 1'b0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adsr_beat_scheduler.sv
// Scoreboard bench: stimulus predicts triggers (edge, period, gate length); a monitor checks them.
module tb_adsr_beat_scheduler;

    localparam int CLK_HZ   = 1000;
    localparam int TICK_HZ  = 250;
    localparam int MIN_BPM  = 40;
    localparam int MAX_BPM  = 200;
    localparam int PERIOD_W = 16;
    localparam int BPM_W    = $clog2(MAX_BPM + 1);
    localparam int TPM      = 60 * TICK_HZ;
    localparam int TDIV     = CLK_HZ / TICK_HZ;
    localparam int NB       = 9;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [BPM_W-1:0]    bpm_estimate = '0;
    logic                bpm_valid = 1'b0;
    logic                sched_enable = 1'b0;
    logic                frame_start = 1'b0;
    logic                tick_4ms;
    logic                beat_trigger;
    logic                gate;
    logic [PERIOD_W-1:0] beat_period_ticks;
    logic                filter_enable_cfg;
    logic                div_busy;

    adsr_beat_scheduler #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MIN_BPM(MIN_BPM), .MAX_BPM(MAX_BPM),
        .BPM_W(BPM_W), .PERIOD_W(PERIOD_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .bpm_estimate      (bpm_estimate),
        .bpm_valid         (bpm_valid),
        .sched_enable      (sched_enable),
        .frame_start       (frame_start),
        .tick_4ms          (tick_4ms),
        .beat_trigger      (beat_trigger),
        .gate              (gate),
        .beat_period_ticks (beat_period_ticks),
        .filter_enable_cfg (filter_enable_cfg),
        .div_busy          (div_busy)
    );

    always #5 clk = ~clk;

    // bench time: number of rising edges since reset was released
    int cyc = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int edge_no;
        int period;
    } exp_t;

    exp_t sb[$];

    // reference model: latest accepted BPM becomes pending; a trigger adopts it
    int act_p;
    int pend_p;
    bit pend_v;

    function automatic int model_period(input int bpm);
        int c;
        c = (bpm < MIN_BPM) ? MIN_BPM : ((bpm > MAX_BPM) ? MAX_BPM : bpm);
        return TPM / c;
    endfunction

    task automatic model_bpm(input int v);
        if (v != 0) begin
            pend_p = model_period(v);
            pend_v = 1'b1;
        end
    endtask

    task automatic model_trigger(input int e);
        if (pend_v) begin
            act_p  = pend_p;
            pend_v = 1'b0;
        end
        sb.push_back('{edge_no: e, period: act_p});
    endtask

    function automatic int first_tick(input int e);
        return ((e / TDIV) + 1) * TDIV;
    endfunction

    // edge at which the (period-1)th tick after the trigger ends the beat
    function automatic int wrap_edge(input int e, input int p);
        return first_tick(e) + TDIV * (p - 2);
    endfunction

    task automatic drive_at(input int k, input bit fs, input bit bv, input int val);
        while (cyc < k - 1) @(negedge clk);
        frame_start  = fs;
        bpm_valid    = bv;
        bpm_estimate = val[BPM_W-1:0];
        @(negedge clk);
        frame_start = 1'b0;
        bpm_valid   = 1'b0;
    endtask

    task automatic wait_to(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    function automatic int pick_bpm(input int b);
        case (b)
            0: return 200;
            1: return 30;
            2: return 0;
            3: return 250;
            default: return ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(20, 250));
        endcase
    endfunction

    // monitor: tick cadence, trigger timing/period, gate length
    exp_t mon_e;
    bit   gate_on = 1'b0;
    int   gate_cnt = 0;
    int   gate_exp = 0;

    always @(negedge clk) begin
        check("tick_4ms", int'(tick_4ms), int'(((cyc + 1) % TDIV) == 0));
        if (beat_trigger) begin
            check("gate_done_before_trigger", int'(gate_on), 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_trigger: trigger at edge %0d, none expected", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("trigger_edge", cyc, mon_e.edge_no);
                check("trigger_period", int'(beat_period_ticks), mon_e.period);
                gate_on  = 1'b1;
                gate_cnt = 0;
                gate_exp = mon_e.period / 2;
            end
        end
        if (gate_on) begin
            if (gate) begin
                if (tick_4ms) gate_cnt++;
            end else begin
                check("gate_ticks", gate_cnt, gate_exp);
                gate_on = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, tw, gap, bm, s, d, n, v;
        bit with_trig, coin;

        act_p  = TPM / MIN_BPM;
        pend_v = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_beat_trigger", int'(beat_trigger), 0);
        check("rst_gate", int'(gate), 0);
        check("rst_filter_enable", int'(filter_enable_cfg), 0);
        check("rst_div_busy", int'(div_busy), 0);
        check("rst_period", int'(beat_period_ticks), 375);
        reset = 1'b0;

        drive_at(cyc + 2, 1'b0, 1'b1, 60);
        model_bpm(60);
        n = 0;
        repeat (30) begin
            if (div_busy) n++;
            @(negedge clk);
        end
        check("div_busy_clocks", n, PERIOD_W);

        // frame_start while disabled must not trigger
        drive_at(cyc + 2, 1'b1, 1'b0, 0);
        sched_enable = 1'b1;
        e = cyc + 3;

        for (int b = 0; b < NB; b++) begin
            v         = pick_bpm(b);
            with_trig = (b == 3) || (b > 4 && $urandom_range(0, 3) == 0);
            coin      = (b == 1) || (b > 4 && $urandom_range(0, 3) == 0);
            model_trigger(e);
            if (with_trig) begin
                drive_at(e, 1'b1, 1'b1, v);
                model_bpm(v);
            end else begin
                drive_at(e, 1'b1, 1'b0, 0);
            end
            tw = wrap_edge(e, act_p);
            if (!with_trig) begin
                bm = e + int'($urandom_range(2, 100));
                drive_at(bm, 1'b0, 1'b1, v);
                model_bpm(v);
                wait_to(bm + 25);
                check("period_held_mid_beat", int'(beat_period_ticks), act_p);
            end
            s = cyc + int'($urandom_range(2, tw - 5 - cyc));
            drive_at(s, 1'b1, 1'b0, 0);
            if (coin) drive_at(tw, 1'b1, 1'b0, 0);
            gap = (b == 2) ? 10 * TDIV : int'($urandom_range(1, 45));
            e = tw + gap;
        end

        // disable mid-RUN after the gate has fallen
        model_trigger(e);
        drive_at(e, 1'b1, 1'b0, 0);
        d = first_tick(e) + TDIV * (act_p / 2) + 3;
        wait_to(d - 1);
        check("filter_enable_in_run", int'(filter_enable_cfg), 1);
        sched_enable = 1'b0;
        @(negedge clk);
        check("disable_gate", int'(gate), 0);
        check("disable_filter_enable", int'(filter_enable_cfg), 0);
        check("disable_period_kept", int'(beat_period_ticks), act_p);

        wait_to(d + 3);
        sched_enable = 1'b1;
        e = cyc + 3;
        model_trigger(e);
        drive_at(e, 1'b1, 1'b0, 0);

        // reset in the middle of a divide
        wait_to(first_tick(e) + TDIV * (act_p / 2) + 8);
        drive_at(cyc + 1, 1'b0, 1'b1, 150);
        repeat (5) @(negedge clk);
        check("busy_before_reset", int'(div_busy), 1);
        reset = 1'b1;
        #1;
        check("reset_div_busy", int'(div_busy), 0);
        check("reset_period", int'(beat_period_ticks), 375);
        check("reset_gate", int'(gate), 0);
        check("reset_filter_enable", int'(filter_enable_cfg), 0);
        @(negedge clk);
        reset = 1'b0;
        // no divide result yet, so frames must not trigger
        drive_at(cyc + 3, 1'b1, 1'b0, 0);
        drive_at(cyc + 4, 1'b1, 1'b0, 0);
        repeat (20) @(negedge clk);
        check("idle_without_result", int'(filter_enable_cfg), 0);
        check("missing_triggers", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
